// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared arbiter FSM encoding and default sizing
package uart_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      START   = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4,
      HOLD    = 3'd5
   } arb_state_t;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx
);

   // Scan from the far end back towards ptr so the last hit is the nearest one.
   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            onehot = '0;
            onehot[(int'(ptr) + k) % N] = 1'b1;
            idx = W'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding one UART transmitter
// Build option UART_ARB_TIMEOUT_EN: revoke a grant left idle in HOLD for TIMEOUT_CYCLES.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ        = DEF_NUM_REQ,
   parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [GW-1:0]        grant_id,
   output logic                 grant_active,
   output logic                 timeout_flag
);

   arb_state_t state, state_nx;
   logic [GW-1:0] ptr, win_idx;
   logic [NUM_REQ-1:0] win_onehot;
   logic [7:0] data_q;
   logic last_q, owner_valid, tx_done, timeout_hit;

   assign owner_valid = req_valid[grant_id];
   assign tx_done     = (state == WAIT_LO) && !tx_busy;
   assign tx_data     = data_q;

   rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .onehot (win_onehot),
      .idx    (win_idx)
   );

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] idle_cnt;

   assign timeout_hit = (state == HOLD) && !owner_valid
                        && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (tx_done)
         idle_cnt <= '0;
      else if ((state == HOLD) && !owner_valid)
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|win_onehot) state_nx = LOAD;
         LOAD:    state_nx = START;
         START:   if (!tx_busy) state_nx = WAIT_HI;
         WAIT_HI: if (tx_busy) state_nx = WAIT_LO;
         WAIT_LO: if (!tx_busy) state_nx = last_q ? IDLE : HOLD;
         HOLD: begin
            if (owner_valid)
               state_nx = LOAD;
            else if (timeout_hit)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready    = '0;
      tx_start     = 1'b0;
      grant_active = (state != IDLE);
      timeout_flag = timeout_hit;
      if (state == LOAD)
         req_ready[grant_id] = 1'b1;
      if ((state == START) && !tx_busy)
         tx_start = 1'b1;
   end

   // Pointer moves past the owner only when its packet ends or is revoked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         grant_id <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         if ((state == IDLE) && (|win_onehot))
            grant_id <= win_idx;
         if (state == LOAD) begin
            data_q <= req_data[8*int'(grant_id) +: 8];
            last_q <= req_last[grant_id];
         end
         if ((tx_done && last_q) || timeout_hit)
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a packet-level model
module tb_uart_tx_arbiter;

   localparam int NUM = 4;

   logic        clk, rst_n;
   logic [3:0]  req_valid, req_last, req_ready;
   logic [31:0] req_data;
   logic        tx_start, tx_busy, grant_active, timeout_flag;
   logic [7:0]  tx_data;
   logic [1:0]  grant_id;

   logic [8:0] strm [NUM][$];
   logic [8:0] mq   [NUM][$];
   logic [9:0] got[$];
   logic [9:0] exp_q[$];

   int   n_asrt = 0, n_fail = 0;
   int   mptr = 0, busy_len = 2, busy_cnt = 0;
   bit   auto_tx = 1'b1, man_busy = 1'b0, start_seen = 1'b0;
   logic [3:0] xfer = '0;

   uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .grant_id     (grant_id),
      .grant_active (grant_active),
      .timeout_flag (timeout_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_asrt++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive requesters and transmitter model after the edge, sample at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++)
         if (xfer[i] && strm[i].size() > 0) void'(strm[i].pop_front());
      for (int i = 0; i < NUM; i++) begin
         req_valid[i] = (strm[i].size() > 0);
         req_data[8*i +: 8] = 8'h00;
         req_last[i] = 1'b0;
         if (strm[i].size() > 0) begin
            req_data[8*i +: 8] = strm[i][0][7:0];
            req_last[i] = strm[i][0][8];
         end
      end
      if (auto_tx) begin
         if (start_seen) begin
            tx_busy  = 1'b1;
            busy_cnt = busy_len - 1;
         end else if (busy_cnt > 0)
            busy_cnt--;
         else
            tx_busy = 1'b0;
      end else
         tx_busy = man_busy;
      start_seen = 1'b0;
      @(negedge clk);
      xfer = req_valid & req_ready;
      if (tx_start) begin
         got.push_back({grant_id, tx_data});
         start_seen = 1'b1;
      end
      chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
`ifndef UART_ARB_TIMEOUT_EN
      chk("timeout_tied", 32'(timeout_flag), 32'd0);
`endif
      #2;
   endtask

   task automatic push_byte(input int id, input logic [7:0] d, input logic l, input bit modeled);
      strm[id].push_back({l, d});
      if (modeled) mq[id].push_back({l, d});
   endtask

   task automatic push_pkt(input int id, input int len);
      for (int b = 0; b < len; b++)
         push_byte(id, 8'($urandom), (b == len - 1), 1'b1);
   endtask

   // Packet-level reference: whole packets leave in round-robin order from the model pointer.
   task automatic model_run();
      logic [8:0] e;
      int id;
      bit more;
      do begin
         more = 1'b0;
         for (int k = 0; k < NUM; k++) begin
            id = (mptr + k) % NUM;
            if (!more && mq[id].size() > 0) begin
               more = 1'b1;
               do begin
                  e = mq[id].pop_front();
                  exp_q.push_back({2'(id), e[7:0]});
               end while (!e[8] && mq[id].size() > 0);
               mptr = (id + 1) % NUM;
            end
         end
      end while (more);
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NUM; i++)
         if (strm[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!(got.size() >= exp_q.size() && !grant_active && all_empty() && !tx_busy)
             && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_bound"}, 32'(n < budget), 32'd1);
      chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++)
         chk({tag, "_byte"}, (j < got.size()) ? 32'(got[j]) : 32'hFFFF_FFFF, 32'(exp_q[j]));
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int n, k, owner, other;
      rst_n = 1'b0;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      tx_busy = 1'b0;

      repeat (3) tick();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_active", 32'(grant_active), 32'd0);
      chk("rst_tflag", 32'(timeout_flag), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single byte from requester 2 with a long transmitter frame.
      busy_len = 160;
      push_byte(2, 8'h55, 1'b1, 1'b1);
      model_run();
      tick();
      chk("lat_n_ready", 32'(req_ready), 32'd0);
      tick();
      chk("lat_n1_ready", 32'(req_ready), 32'h4);
      tick();
      chk("lat_n2_start", 32'(tx_start), 32'd1);
      chk("lat_n2_data", 32'(tx_data), 32'h55);
      tick();
      chk("lat_n3_start", 32'(tx_start), 32'd0);
      chk("lat_n3_active", 32'(grant_active), 32'd1);
      wait_done("single", 400);
      chk("idle_gid_hold", 32'(grant_id), 32'd2);

      // Pointer now past requester 2: 3 must beat 0.
      busy_len = 2;
      push_byte(0, 8'hA0, 1'b1, 1'b1);
      push_byte(3, 8'hA3, 1'b1, 1'b1);
      model_run();
      wait_done("ptr3", 100);

      for (int r = 0; r < 3; r++) begin
         busy_len = $urandom_range(1, 5);
         for (int i = 0; i < NUM; i++)
            for (int p = $urandom_range(0, 2); p > 0; p--)
               push_pkt(i, $urandom_range(1, 3));
         model_run();
         wait_done("rand", 50 + 20 * exp_q.size());
      end

      // Packet lock: requester 0 arrives after requester 1 is granted.
      push_byte(1, 8'h01, 1'b0, 1'b0);
      push_byte(1, 8'h02, 1'b0, 1'b0);
      push_byte(1, 8'h03, 1'b1, 1'b0);
      n = 0;
      while (!grant_active && n < 10) begin tick(); n++; end
      chk("lock_grant", 32'(grant_id), 32'd1);
      push_byte(0, 8'h44, 1'b1, 1'b0);
      exp_q = '{10'h101, 10'h102, 10'h103, 10'h044};
      mptr = 1;
      wait_done("lock", 200);

      // Transmitter busy on START entry for 20 cycles.
      auto_tx = 1'b0;
      man_busy = 1'b1;
      push_byte(1, 8'hA5, 1'b1, 1'b1);
      model_run();
      repeat (22) tick();
      chk("stall_nopulse", 32'(got.size()), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      man_busy = 1'b0;
      tick();
      chk("stall_start", 32'(tx_start), 32'd1);
      chk("stall_data", 32'(tx_data), 32'hA5);
      man_busy = 1'b1;
      tick();
      chk("stall_single", 32'(tx_start), 32'd0);
      repeat (3) tick();
      man_busy = 1'b0;
      auto_tx = 1'b1;
      wait_done("stall", 50);

      // Owner stops after the first byte of a packet while another requester waits.
      busy_len = 3;
      owner = mptr;
      other = (mptr + 2) % NUM;
      push_byte(owner, 8'h11, 1'b0, 1'b0);
      push_byte(other, 8'h22, 1'b1, 1'b0);
      n = 0;
      while (got.size() < 1 && n < 20) begin tick(); n++; end
      chk("to_first", 32'(got.size()), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
      k = 0;
      while (!timeout_flag && k < 60) begin tick(); k++; end
      chk("to_flag_cycle", 32'(k), 32'(busy_len + 17));
      tick();
      chk("to_flag_pulse", 32'(timeout_flag), 32'd0);
      exp_q = '{{2'(owner), 8'h11}, {2'(other), 8'h22}};
`else
      k = 0;
      repeat (40) tick();
      chk("keep_active", 32'(grant_active), 32'd1);
      chk("keep_gid", 32'(grant_id), 32'(owner));
      chk("keep_nosend", 32'(got.size()), 32'd1 + 32'(k));
      push_byte(owner, 8'h33, 1'b1, 1'b0);
      exp_q = '{{2'(owner), 8'h11}, {2'(owner), 8'h33}, {2'(other), 8'h22}};
`endif
      mptr = (other + 1) % NUM;
      wait_done("timeout", 200);

      // Reset while the transmitter frame is in progress.
      busy_len = 10;
      push_byte(3, 8'h77, 1'b1, 1'b0);
      n = 0;
      while (!tx_busy && n < 20) begin tick(); n++; end
      chk("mid_busy", 32'(tx_busy), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_ready", 32'(req_ready), 32'd0);
      chk("mid_start", 32'(tx_start), 32'd0);
      chk("mid_data", 32'(tx_data), 32'd0);
      chk("mid_gid", 32'(grant_id), 32'd0);
      chk("mid_active", 32'(grant_active), 32'd0);
      chk("mid_tflag", 32'(timeout_flag), 32'd0);
      for (int i = 0; i < NUM; i++) begin
         strm[i].delete();
         mq[i].delete();
      end
      got.delete();
      exp_q.delete();
      mptr = 0;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("mid_noresume", 32'(got.size()), 32'd0);
      chk("mid_idle", 32'(grant_active), 32'd0);

      // Fairness from pointer 0 with every requester continuously loaded.
      busy_len = 2;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NUM; i++)
            push_pkt(i, 1);
      model_run();
      wait_done("fair", 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, mid-packet idle limit in clk cycles (timeout feature only).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  byte is final byte of packet.
REQ-008 req_ready  output  NUM_REQ  byte accepted this cycle (valid&ready = transfer).
REQ-009 tx_start  output  1  one-cycle pulse launching transmitter frame.
REQ-010 tx_data  output  8  byte to transmit; stable from tx_start until next accepted byte.
REQ-011 tx_busy  input  1  transmitter frame in progress.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of current owner.
REQ-013 grant_active  output  1  a packet grant is held.
REQ-014 timeout_flag  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, WAIT_HI, WAIT_LO, HOLD.
REQ-016 IDLE: if any req_valid, select winner round-robin, latch grant_id, go LOAD; else stay.
REQ-017 Round-robin: search starts at pointer, ascending modulo NUM_REQ; pointer = winner+1 mod NUM_REQ at packet end or timeout; pointer = 0 after reset.
REQ-018 LOAD: req_ready[grant_id]=1 for exactly one cycle; capture req_data/req_last of owner; go START; all other req_ready bits always 0.
REQ-019 START: if tx_busy=0 assert tx_start one cycle with captured byte, go WAIT_HI; if tx_busy=1 stall in START, no pulse.
REQ-020 WAIT_HI waits for tx_busy=1, then WAIT_LO waits for tx_busy=0.
REQ-021 On leaving WAIT_LO: captured last=1 -> IDLE with pointer advanced; last=0 -> HOLD.
REQ-022 HOLD: req_valid[grant_id]=1 -> LOAD; other requesters ignored (packet lock).
REQ-023 Latency: req_valid in IDLE at cycle n -> req_ready at n+1 -> tx_start at n+2 (tx_busy=0).
REQ-024 grant_active=1 in all states except IDLE; grant_id holds last owner while idle.
REQ-025 Simultaneous requests in IDLE resolved only by REQ-017; req_valid changes outside IDLE/HOLD have no effect.

Reset
REQ-026 Reset SHALL force IDLE, pointer 0, req_ready 0, tx_start 0, tx_data 0x00, grant_id 0, grant_active 0, timeout_flag 0, timeout counter 0.
REQ-027 Reset mid-packet SHALL abort immediately; partially sent packet is not resumed.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: counter clears on HOLD entry, increments each HOLD cycle with req_valid[grant_id]=0; reaching TIMEOUT_CYCLES -> IDLE, pointer advanced, timeout_flag pulses one cycle.
REQ-029 Macro undefined: HOLD waits indefinitely; no counter logic; timeout_flag tied 0.

Structure
REQ-030 Shared package uart_arb_pkg SHALL hold FSM state encoding, default NUM_REQ and TIMEOUT_CYCLES constants.
REQ-031 Round-robin selection SHALL be sub-module rr_pick (request vector + pointer in, one-hot winner and index out, combinational).

Verification
REQ-032 Single: req 2 sends 0x55 last=1, tx_busy rises 1 cycle after tx_start, 160 cycles -> req_ready[2] at n+1, tx_start at n+2 with tx_data 0x55, back to IDLE, pointer 3.
REQ-033 Fairness: all 4 requesters hold one-byte packets continuously -> grant order 0,1,2,3,0; no requester served twice before others.
REQ-034 Lock: req 1 sends 3-byte packet 0x01,0x02,0x03 while req 0 valid -> all three bytes sent before req 0 granted.
REQ-035 Busy stall: tx_busy held 1 for 20 cycles on START entry -> tx_start withheld until busy low, then single pulse.
REQ-036 Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): owner drops valid after byte 1 of packet -> timeout_flag pulse after 16 HOLD cycles, next requester granted; without macro owner retains grant.
REQ-037 Reset: rst_n low during WAIT_LO -> all outputs at REQ-026 values same cycle; new request after release served normally from pointer 0.
